decode_stage_nw: RTL

//  - Registered, parametrised N-wide RV32I decode stage: successor to the combinational two-lane decoder.
//  - Accepts a bundle of ISSUE_WIDTH instructions plus bundle PC and decodes each lane: op class, sub-op, rs1/rs2/rd, imm, shamt, illegal.
//  - Emits decode results one cycle later through a valid/ready pipeline register with a one-entry skid buffer.
//  - Sits between fetch bundle queue and rename/issue; lane 0 is the oldest instruction.

---
 rtl/decode_pkg.sv | 47 ++++
 rtl/dec_lane.sv | 82 ++++++++
 rtl/decode_stage_nw.sv | 139 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the N-wide RV32I decode stage: major opcode values
// (inst[6:2]), the per-lane decode record, and immediate-extraction helpers.
package decode_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // RV32I decode record; field widths are fixed by the ISA.
  typedef struct packed {
    logic [4:0]  op_code;
    logic [3:0]  sub_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        illegal;
  } dec_lane_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/dec_lane.sv
// Combinational single-instruction RV32I decoder. An invalid lane yields an
// all-zero record; an unsupported encoding on a valid lane sets only illegal.
module dec_lane
  import decode_pkg::*;
(
  input  logic        vld_i,
  input  logic [31:0] inst_i,
  output dec_lane_t   dec_o
);

  logic [4:0] opc_s;
  logic [2:0] f3_s;

  assign opc_s = inst_i[6:2];
  assign f3_s  = inst_i[14:12];

  // Field extraction per major opcode; unused register indices stay zero
  always_comb begin
    dec_o = '0;
    if (vld_i && (inst_i[1:0] == 2'b11)) begin
      case (opc_s)
        OPC_LUI, OPC_AUIPC: begin
          dec_o.rd  = inst_i[11:7];
          dec_o.imm = imm_u(inst_i);
        end
        OPC_OP_IMM: begin
          dec_o.rs1    = inst_i[19:15];
          dec_o.rd     = inst_i[11:7];
          dec_o.imm    = imm_i(inst_i);
          dec_o.sub_op = {(f3_s == 3'b101) ? inst_i[30] : 1'b0, f3_s};
          dec_o.shamt  = inst_i[24:20];
        end
        OPC_OP: begin
          dec_o.rs1    = inst_i[19:15];
          dec_o.rs2    = inst_i[24:20];
          dec_o.rd     = inst_i[11:7];
          dec_o.sub_op = {inst_i[30], f3_s};
          dec_o.shamt  = inst_i[24:20];
        end
        OPC_LOAD: begin
          dec_o.rs1    = inst_i[19:15];
          dec_o.rd     = inst_i[11:7];
          dec_o.imm    = imm_i(inst_i);
          dec_o.sub_op = {1'b0, f3_s};
        end
        OPC_STORE: begin
          dec_o.rs1    = inst_i[19:15];
          dec_o.rs2    = inst_i[24:20];
          dec_o.imm    = imm_s(inst_i);
          dec_o.sub_op = {1'b0, f3_s};
        end
        OPC_BRANCH: begin
          dec_o.rs1    = inst_i[19:15];
          dec_o.rs2    = inst_i[24:20];
          dec_o.imm    = imm_b(inst_i);
          dec_o.sub_op = {1'b0, f3_s};
        end
        OPC_JAL: begin
          dec_o.rd     = inst_i[11:7];
          dec_o.imm    = imm_j(inst_i);
          dec_o.sub_op = 4'b1111;
        end
        OPC_JALR: begin
          dec_o.rs1 = inst_i[19:15];
          dec_o.rd  = inst_i[11:7];
          dec_o.imm = imm_i(inst_i);
        end
        default: dec_o.illegal = 1'b1;
      endcase
      if (dec_o.illegal) begin
        dec_o.op_code = 5'd0;
      end else begin
        dec_o.op_code = opc_s;
      end
    end else if (vld_i) begin
      dec_o.illegal = 1'b1;
    end else begin
      dec_o = '0;
    end
  end

endmodule

// File: rtl/decode_stage_nw.sv
// Registered N-wide RV32I decode stage with a valid/ready output register and
// a one-entry skid buffer. Lane 0 is the oldest instruction of a bundle.
// Optional feature: define DECODE_RAW_CHECK_EN to build the intra-bundle
// read-after-write comparator; otherwise raw_hazard is constant zero.
module decode_stage_nw
  import decode_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int XLEN        = 32,
  parameter int RS          = 5,
  parameter int RD          = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ISSUE_WIDTH-1:0]              in_lane_vld,
  input  logic [ISSUE_WIDTH-1:0][31:0]        in_inst,
  input  logic [XLEN-1:0]                     in_pc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ISSUE_WIDTH-1:0]              out_lane_vld,
  output logic [XLEN-1:0]                     out_pc,
  output logic [ISSUE_WIDTH-1:0][4:0]         op_code,
  output logic [ISSUE_WIDTH-1:0][3:0]         sub_op_code,
  output logic [ISSUE_WIDTH-1:0][RS-1:0]      rs1,
  output logic [ISSUE_WIDTH-1:0][RS-1:0]      rs2,
  output logic [ISSUE_WIDTH-1:0][RD-1:0]      rd,
  output logic [ISSUE_WIDTH-1:0][XLEN-1:0]    imm,
  output logic [ISSUE_WIDTH-1:0][4:0]         shift_size,
  output logic [ISSUE_WIDTH-1:0]              illegal,
  output logic [ISSUE_WIDTH-1:0]              raw_hazard
);

  typedef struct packed {
    logic [ISSUE_WIDTH-1:0] lane_vld;
    logic [XLEN-1:0]        pc;
    dec_lane_t [ISSUE_WIDTH-1:0] lanes;
    logic [ISSUE_WIDTH-1:0] raw;
  } bundle_t;

  dec_lane_t [ISSUE_WIDTH-1:0] dec_s;
  logic [ISSUE_WIDTH-1:0]      raw_s;
  bundle_t                     in_bundle_s;
  bundle_t                     out_q, out_d, skid_q, skid_d;
  logic                        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic                        xfer_s, accept_s;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
    dec_lane u_dec_lane (
      .vld_i  (in_lane_vld[g]),
      .inst_i (in_inst[g]),
      .dec_o  (dec_s[g])
    );
  end

`ifdef DECODE_RAW_CHECK_EN
  // Flag a younger lane whose used source matches an older lane's nonzero rd
  always_comb begin
    raw_s = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int j = 0; j < k; j++) begin
        raw_s[k] = raw_s[k] | (in_lane_vld[j] & in_lane_vld[k] &
                               (dec_s[j].rd != 5'd0) &
                               ((dec_s[j].rd == dec_s[k].rs1) |
                                (dec_s[j].rd == dec_s[k].rs2)));
      end
    end
  end
`else
  assign raw_s = '0;
`endif

  assign in_bundle_s = '{lane_vld: in_lane_vld, pc: in_pc, lanes: dec_s, raw: raw_s};
  assign in_ready    = !skid_vld_q;
  assign xfer_s      = in_valid & in_ready;
  assign accept_s    = out_vld_q & out_ready;

  // Pipeline/skid next state; flush overrides everything, skid drains first
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || accept_s) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (xfer_s) begin
        out_d     = in_bundle_s;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (xfer_s) begin
      skid_d     = in_bundle_s;
      skid_vld_d = 1'b1;
    end else begin
      skid_vld_d = skid_vld_q;
    end
  end

  // Output and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid    = out_vld_q;
  assign out_lane_vld = out_q.lane_vld;
  assign out_pc       = out_q.pc;
  assign raw_hazard   = out_q.raw;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_out
    assign op_code[g]     = out_q.lanes[g].op_code;
    assign sub_op_code[g] = out_q.lanes[g].sub_op;
    assign rs1[g]         = out_q.lanes[g].rs1;
    assign rs2[g]         = out_q.lanes[g].rs2;
    assign rd[g]          = out_q.lanes[g].rd;
    assign imm[g]         = out_q.lanes[g].imm;
    assign shift_size[g]  = out_q.lanes[g].shamt;
    assign illegal[g]     = out_q.lanes[g].illegal;
  end

endmodule
